multdiv_sequencer: RTL
======================

Name: multdiv_sequencer

Overview:
- Controls an iterative multiply/divide unit that sits beside the ALU in the X stage of the 5-stage pipeline.
- Detects mul/div in the DX latch and issues a one-cycle start pulse to the unit.
- While the operation runs it stalls PC/FD/DX and injects bubbles into XM.
- When the result arrives it presents result, destination register and exception status for one cycle, then releases the pipeline.

Parameters:
MAX_CYCLES, 40, busy cycles allowed before a timeout is forced (must be ≥2)
CNT_W, 6, width of busy counter (2^CNT_W > MAX_CYCLES)

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-low reset
dx_ir  in  32  instruction in DX latch
dx_valid  in  1  DX holds a real (non-bubble) instruction
flush  in  1  branch/jump kill of the DX instruction
md_result  in  32  result from multdiv unit
md_exception  in  1  overflow/div-by-zero from multdiv unit
md_ready  in  1  multdiv result valid
ctrl_mult  out  1  start multiply pulse
ctrl_div  out  1  start divide pulse
stall  out  1  hold PC, FD, DX
xm_bubble  out  1  load nop into XM
result  out  32  captured result
result_rd  out  5  destination register (captured dx_ir[26:22])
result_valid  out  1  result/result_rd valid, one cycle
result_exc  out  1  exception on this result
exc_code  out  32  rstatus value: 4 mul, 5 div, 6 timeout, 0 none

Behaviour:
- Decode (combinational): match = dx_valid & !flush & dx_ir[31:27]==00000 & (dx_ir[6:2]==00110 mul | 00111 div).
- States: IDLE, BUSY, DONE, 2-bit encoded.
- Reset (reset==0, async): state=IDLE, counter=0, result=0, result_rd=0, result_exc=0, exc_code=0, op flag=0. All outputs 0 while held.
- IDLE:
  - ctrl_mult = match&mul and ctrl_div = match&div, both combinational. Exactly one cycle each, since state leaves IDLE.
  - stall = xm_bubble = match.
  - On match: latch op type and dx_ir[26:22]; clear counter; next state BUSY.
  - md_ready in IDLE is ignored.
- BUSY:
  - stall=1, xm_bubble=1; ctrl_* = 0; counter +1 per cycle.
  - flush=1 has priority over everything: next state IDLE, no result, md_ready that cycle ignored.
  - Else md_ready=1: capture md_result; result_exc = md_exception; exc_code = md_exception ? (mul?4:5) : 0; next DONE.
  - Else counter==MAX_CYCLES-1: result=0, result_exc=1, exc_code=6, next DONE.
- DONE (exactly one cycle):
  - result_valid=1, stall=0, xm_bubble=0.
  - The mul/div advances DX→XM at the end of this cycle with result/result_exc/exc_code; next state IDLE.
  - No decode in DONE, so the same instruction cannot retrigger.
  - The instruction entering DX after DONE is decoded fresh in IDLE, so back-to-back mul/div costs one IDLE start cycle.
- result, result_rd, result_exc, exc_code hold their last captured values outside DONE. Only result_valid qualifies them.
- Latency: start in cycle 0; md_ready in cycle N (N≥1) gives DONE in cycle N+1. Stall is high cycles 0..N.

Test Plan:
- mul r3,r1,r2 with 3 and 7; md_ready 32 cycles after start -> ctrl_mult one cycle; stall high 33 cycles; DONE with result=21, result_rd=3, result_exc=0, exc_code=0.
- div r4,r1,r2 with 5 and 0; md_ready+md_exception after 33 cycles -> result_valid=1, result_exc=1, exc_code=5, result_rd=4.
- Mul starts; flush asserted in BUSY cycle 10; md_ready in the same cycle -> state IDLE next edge, stall drops, no result_valid ever, ctrl pulses not repeated.
- md_ready never asserted, MAX_CYCLES=40 -> DONE after 40 BUSY cycles with result_exc=1, exc_code=6, result=0.
- Two consecutive mul in DX (ready after 5 each) -> two distinct ctrl_mult pulses separated by DONE+IDLE; two result_valid pulses with the correct rd values.
- reset driven low mid-BUSY, asynchronously between edges -> stall, xm_bubble and all outputs 0 immediately; state IDLE; a later mul starts normally.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Signal bundle between the X-stage pipeline/multdiv unit and the multdiv sequencer.
// The slave modport is the sequencer's view; the master modport is the pipeline and multdiv-unit side.
interface multdiv_sequencer_if;
  // Handshake: md_ready qualifies md_result/md_exception for exactly the cycle it is high.
  // result_valid qualifies result/result_rd/result_exc/exc_code for exactly one cycle.
  // Neither side can apply backpressure; ctrl_mult/ctrl_div are single-cycle start pulses.
  logic [31:0] dx_ir;
  logic        dx_valid;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        xm_bubble;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_valid;
  logic        result_exc;
  logic [31:0] exc_code;
  logic [1:0]  state_dbg;

  modport slave (
    input  dx_ir, dx_valid, flush, md_result, md_exception, md_ready,
    output ctrl_mult, ctrl_div, stall, xm_bubble, result, result_rd,
           result_valid, result_exc, exc_code, state_dbg
  );

  modport master (
    output dx_ir, dx_valid, flush, md_result, md_exception, md_ready,
    input  ctrl_mult, ctrl_div, stall, xm_bubble, result, result_rd,
           result_valid, result_exc, exc_code, state_dbg
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences an iterative mul/div unit from the DX latch: start pulse, pipeline stall,
// bounded wait for the result, then a one-cycle DONE presenting result and status.
module multdiv_sequencer #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_mul;
  logic [31:0]      result_q;
  logic [4:0]       rd_q;
  logic             exc_q;
  logic [31:0]      code_q;

  logic is_mul;
  logic is_div;
  logic match;
  logic unused_ir;

  always_comb begin
    is_mul = (bus.dx_ir[31:27] == 5'b00000) && (bus.dx_ir[6:2] == 5'b00110);
    is_div = (bus.dx_ir[31:27] == 5'b00000) && (bus.dx_ir[6:2] == 5'b00111);
    match  = bus.dx_valid && !bus.flush && (is_mul || is_div);
  end

  assign unused_ir = ^{bus.dx_ir[21:7], bus.dx_ir[1:0]};

  // Combinational outputs are gated by reset so nothing leaks out while it is held low.
  assign bus.ctrl_mult    = reset && (state == IDLE) && match && is_mul;
  assign bus.ctrl_div     = reset && (state == IDLE) && match && is_div;
  assign bus.stall        = reset && (((state == IDLE) && match) || (state == BUSY));
  assign bus.xm_bubble    = reset && (((state == IDLE) && match) || (state == BUSY));
  assign bus.result_valid = reset && (state == DONE);
  assign bus.result       = result_q;
  assign bus.result_rd    = rd_q;
  assign bus.result_exc   = exc_q;
  assign bus.exc_code     = code_q;
  assign bus.state_dbg    = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_mul   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      exc_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            op_mul <= is_mul;
            rd_q   <= bus.dx_ir[26:22];
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // A killed instruction abandons the operation even if its result lands now.
          if (bus.flush) begin
            state <= IDLE;
          end else if (bus.md_ready) begin
            result_q <= bus.md_result;
            exc_q    <= bus.md_exception;
            code_q   <= bus.md_exception ? (op_mul ? 32'd4 : 32'd5) : 32'd0;
            state    <= DONE;
          end else if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            code_q   <= 32'd6;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
